uart_rx_frame_fifo: RTL and testbench

UART_RX_FRAME_FIFO -- requirements
Module: uart_rx_frame_fifo

---
 rtl/uart_rx_frame_fifo.sv | 125 ++++++++++++
 tb/tb_uart_rx_frame_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_fifo.sv
// uart_rx_frame_fifo
// Validates raw UART frames (start/stop, optional parity) and queues the
// payload of good frames in a small first-word-fall-through FIFO.
// Sticky error flags report framing, parity and overflow faults.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit to the
// frame and enable the parity check (sense chosen by PARITY_ODD).
module uart_rx_frame_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 4,
  parameter bit PARITY_ODD = 1'b0,
`ifdef UART_RX_PARITY_EN
  localparam int FW = DATA_W + 3
`else
  localparam int FW = DATA_W + 2
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [FW-1:0]            frame_in,
  input  logic                     frame_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     frame_err,
  output logic                     parity_err,
  output logic                     overflow,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_ptr_nx;

  logic [DATA_W-1:0] data;
  logic              framing_bad;
  logic              good;
  logic              full;
  logic              pop;
  logic              push;
  logic              ovf_set;

  assign data        = frame_in[DATA_W:1];
  assign framing_bad = frame_in[0] | ~frame_in[FW-1];

`ifdef UART_RX_PARITY_EN
  logic parity_bad;
  // Data plus parity bit must XOR to the selected sense (0 even, 1 odd).
  assign parity_bad = (^{data, frame_in[DATA_W+1]}) != PARITY_ODD;
  assign good       = ~framing_bad & ~parity_bad;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
  assign good              = ~framing_bad;
`endif

  assign rd_valid  = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop       = rd_valid & rd_ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign push      = frame_valid & good & (~full | pop);
  assign ovf_set   = frame_valid & good & full & ~pop;
  assign rd_ptr_nx = rd_ptr + AW'(1);

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  // Pointers, occupancy and the registered head-of-queue output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr_nx;
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // Head after a pop is the next stored entry, or the incoming word
      // when the popped entry was the last one; otherwise rd_data holds.
      if (pop) begin
        if (count > (AW+1)'(1))
          rd_data <= mem[rd_ptr_nx];
        else if (push)
          rd_data <= data;
      end else if (push && !rd_valid) begin
        rd_data <= data;
      end
    end
  end

  // Sticky framing and overflow flags; a new fault wins over clr_err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (frame_valid && framing_bad) frame_err <= 1'b1;
      else if (clr_err)               frame_err <= 1'b0;
      if (ovf_set)                    overflow  <= 1'b1;
      else if (clr_err)               overflow  <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Sticky parity flag; a new fault wins over clr_err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          parity_err <= 1'b0;
    else if (frame_valid && parity_bad) parity_err <= 1'b1;
    else if (clr_err)                   parity_err <= 1'b0;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_fifo.sv
// Bench for uart_rx_frame_fifo: directed scenarios plus a randomized run,
// all checked against a queue-based reference model.
module tb_uart_rx_frame_fifo;

  localparam int DATA_W     = 8;
  localparam int DEPTH      = 4;
  localparam bit PARITY_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int FW = DATA_W + 3;
`else
  localparam int FW = DATA_W + 2;
`endif
  localparam int CW = $clog2(DEPTH) + 1;

  logic              clk;
  logic              reset;
  logic [FW-1:0]     frame_in;
  logic              frame_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [CW-1:0]     count;
  logic              frame_err;
  logic              parity_err;
  logic              overflow;
  logic              clr_err;

  uart_rx_frame_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PARITY_ODD(PARITY_ODD)) dut (
    .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .count(count),
    .frame_err(frame_err), .parity_err(parity_err), .overflow(overflow),
    .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: payload queue, last head value, sticky flags.
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_last;
  bit m_fe, m_pe, m_ov;

  function automatic logic [FW-1:0] make_frame(input logic [DATA_W-1:0] d,
                                               input bit bad_start, input bit bad_stop);
    logic [FW-1:0] f;
    f = '0;
    f[0] = bad_start;
    f[DATA_W:1] = d;
`ifdef UART_RX_PARITY_EN
    f[DATA_W+1] = (^d) ^ PARITY_ODD;
`endif
    f[FW-1] = ~bad_stop;
    return f;
  endfunction

  task automatic model_reset();
    q.delete();
    m_last = '0;
    m_fe = 0; m_pe = 0; m_ov = 0;
  endtask

  task automatic model_step(input bit fv, input logic [FW-1:0] f, input bit rr, input bit clr);
    bit popm, fbad, pbad, was_full, ovs;
    logic [DATA_W-1:0] d;
    d = f[DATA_W:1];
    fbad = (f[0] != 1'b0) || (f[FW-1] != 1'b1);
    pbad = 0;
`ifdef UART_RX_PARITY_EN
    pbad = ((^d) ^ f[DATA_W+1]) != PARITY_ODD;
`endif
    was_full = (q.size() == DEPTH);
    popm = rr && (q.size() > 0);
    ovs = 0;
    if (popm) void'(q.pop_front());
    if (fv && !fbad && !pbad) begin
      if (!was_full || popm) q.push_back(d);
      else ovs = 1;
    end
    if (q.size() > 0) m_last = q[0];
    if (fv && fbad) m_fe = 1; else if (clr) m_fe = 0;
    if (fv && pbad) m_pe = 1; else if (clr) m_pe = 0;
    if (ovs)        m_ov = 1; else if (clr) m_ov = 0;
  endtask

  // One clock: drive at negedge, advance model, return at next negedge.
  task automatic cyc(input bit fv, input logic [FW-1:0] f, input bit rr, input bit clr);
    frame_valid = fv; frame_in = f; rd_ready = rr; clr_err = clr;
    model_step(fv, f, rr, clr);
    @(posedge clk);
    @(negedge clk);
    frame_valid = 0; rd_ready = 0; clr_err = 0;
    frame_in = FW'($urandom);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (count !== '0)      begin n_bad++; $display("FAIL rst_count got %0d want 0", count); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rd_valid got %b want 0", rd_valid); end
    n_cmp++; if (rd_data !== '0)    begin n_bad++; $display("FAIL rst_rd_data got %h want 0", rd_data); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL rst_frame_err got %b want 0", frame_err); end
    n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL rst_parity_err got %b want 0", parity_err); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow got %b want 0", overflow); end
    reset = 0;
    model_reset();
  endtask

  task automatic test_basic();
    cyc(1, make_frame(8'hA5, 0, 0), 0, 0);
    n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL basic_rd_valid got %b want 1", rd_valid); end
    n_cmp++; if (rd_data !== 8'hA5) begin n_bad++; $display("FAIL basic_rd_data got %h want a5", rd_data); end
    n_cmp++; if (count !== CW'(1))  begin n_bad++; $display("FAIL basic_count got %0d want 1", count); end
    cyc(0, '0, 1, 0);
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pop_valid got %b want 0", rd_valid); end
    cyc(0, '0, 1, 0);
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL basic_empty_pop_count got %0d want 0", count); end
    n_cmp++; if (rd_data !== 8'hA5) begin n_bad++; $display("FAIL basic_hold got %h want a5", rd_data); end
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] d[5];
    for (int i = 0; i < 5; i++) begin
      d[i] = DATA_W'($urandom);
      cyc(1, make_frame(d[i], 0, 0), 0, 0);
    end
    n_cmp++; if (count !== CW'(DEPTH)) begin n_bad++; $display("FAIL ovf_count got %0d want %0d", count, DEPTH); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== d[i]) begin
        n_bad++; $display("FAIL ovf_drain%0d got %h/%b want %h/1", i, rd_data, rd_valid, d[i]);
      end
      cyc(0, '0, 1, 0);
    end
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL ovf_drained_count got %0d want 0", count); end
    cyc(0, '0, 0, 1);
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clr got %b want 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [DATA_W-1:0] d[5];
    for (int i = 0; i < 5; i++) d[i] = DATA_W'($urandom);
    for (int i = 0; i < 4; i++) cyc(1, make_frame(d[i], 0, 0), 0, 0);
    cyc(1, make_frame(d[4], 0, 0), 1, 0);
    n_cmp++; if (count !== CW'(DEPTH)) begin n_bad++; $display("FAIL fpp_count got %0d want %0d", count, DEPTH); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_overflow got %b want 0", overflow); end
    for (int i = 1; i < 5; i++) begin
      n_cmp++;
      if (rd_data !== d[i]) begin n_bad++; $display("FAIL fpp_drain%0d got %h want %h", i, rd_data, d[i]); end
      cyc(0, '0, 1, 0);
    end
  endtask

  task automatic test_frame_err();
    logic [DATA_W-1:0] d;
    d = DATA_W'($urandom);
    cyc(1, make_frame(d, 0, 0), 0, 0);
    cyc(1, make_frame(DATA_W'($urandom), 0, 1), 0, 0);
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_set got %b want 1", frame_err); end
    n_cmp++; if (count !== CW'(1)) begin n_bad++; $display("FAIL ferr_count got %0d want 1", count); end
    cyc(1, make_frame(DATA_W'($urandom), 1, 0), 0, 1);
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_priority got %b want 1", frame_err); end
    cyc(0, '0, 0, 1);
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL ferr_clr got %b want 0", frame_err); end
    n_cmp++; if (rd_data !== d) begin n_bad++; $display("FAIL ferr_data got %h want %h", rd_data, d); end
    cyc(0, '0, 1, 0);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [FW-1:0] f;
    f = '0; f[DATA_W:1] = 8'h01; f[FW-1] = 1'b1; f[DATA_W+1] = 1'b0;
    cyc(1, f, 0, 0);
    n_cmp++; if (parity_err !== 1'b1) begin n_bad++; $display("FAIL par_err got %b want 1", parity_err); end
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL par_bad_count got %0d want 0", count); end
    f[DATA_W+1] = 1'b1;
    cyc(1, f, 0, 1);
    n_cmp++; if (count !== CW'(1) || rd_data !== 8'h01) begin
      n_bad++; $display("FAIL par_good got %0d/%h want 1/01", count, rd_data);
    end
    n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL par_clr got %b want 0", parity_err); end
    cyc(0, '0, 1, 0);
  endtask
`endif

  task automatic test_reset_mid();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 3; i++) cyc(1, make_frame(DATA_W'($urandom), 0, 0), 0, 0);
    #2 reset = 1;
    #1;
    n_cmp++; if (count !== '0)      begin n_bad++; $display("FAIL rmid_count got %0d want 0", count); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_rd_valid got %b want 0", rd_valid); end
    n_cmp++; if (rd_data !== '0)    begin n_bad++; $display("FAIL rmid_rd_data got %h want 0", rd_data); end
    model_reset();
    frame_valid = 1; frame_in = make_frame(DATA_W'($urandom), 0, 0);
    @(posedge clk); @(negedge clk);
    frame_valid = 0;
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL rmid_ignored got %0d want 0", count); end
    reset = 0;
    d = DATA_W'($urandom);
    cyc(1, make_frame(d, 0, 0), 0, 0);
    n_cmp++; if (count !== CW'(1) || rd_data !== d) begin
      n_bad++; $display("FAIL rmid_first_write got %0d/%h want 1/%h", count, rd_data, d);
    end
    cyc(0, '0, 1, 0);
  endtask

  task automatic test_random();
    bit fv, rr, clr;
    int kind;
    logic [FW-1:0] f;
    for (int c = 0; c < 800; c++) begin
      fv   = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 9);
      f = make_frame(DATA_W'($urandom), kind == 0, kind == 1);
`ifdef UART_RX_PARITY_EN
      if (kind == 2) f[DATA_W+1] = ~f[DATA_W+1];
`endif
      rr  = ($urandom_range(0, 9) < 4);
      clr = ($urandom_range(0, 15) == 0);
      cyc(fv, f, rr, clr);
      n_cmp++; if (count !== CW'(q.size())) begin n_bad++; $display("FAIL rnd_count c%0d got %0d want %0d", c, count, q.size()); end
      n_cmp++; if (rd_valid !== (q.size() != 0)) begin n_bad++; $display("FAIL rnd_valid c%0d got %b want %b", c, rd_valid, q.size() != 0); end
      n_cmp++; if (rd_data !== m_last) begin n_bad++; $display("FAIL rnd_data c%0d got %h want %h", c, rd_data, m_last); end
      n_cmp++; if ({frame_err, parity_err, overflow} !== {m_fe, m_pe, m_ov}) begin
        n_bad++; $display("FAIL rnd_flags c%0d got %b%b%b want %b%b%b", c,
                          frame_err, parity_err, overflow, m_fe, m_pe, m_ov);
      end
    end
  endtask

  initial begin
    reset = 1; frame_in = '0; frame_valid = 0; rd_ready = 0; clr_err = 0;
    model_reset();
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_frame_err();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
